// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared SRAM geometry for the block-memory subsystem
package mem_pkg;
   parameter int ADDR_W     = 8;
   parameter int BLOCK_BITS = 8;
endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM command/response bundle for sram_arbiter
interface sram_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS
) ();
   logic [NUM_PORTS-1:0]                 wr_req;
   logic [NUM_PORTS-1:0][ADDR_W-1:0]     wr_addr;
   logic [NUM_PORTS-1:0][BLOCK_BITS-1:0] wr_data;
   logic [NUM_PORTS-1:0]                 wr_gnt;
   logic [NUM_PORTS-1:0]                 rd_req;
   logic [NUM_PORTS-1:0][ADDR_W-1:0]     rd_addr;
   logic [NUM_PORTS-1:0]                 rd_gnt;
   logic [BLOCK_BITS-1:0]                rd_data;
   logic [NUM_PORTS-1:0]                 rd_valid;
   logic                                 mem_we;
   logic                                 mem_re;
   logic [ADDR_W-1:0]                    mem_w_addr;
   logic [ADDR_W-1:0]                    mem_r_addr;
   logic [BLOCK_BITS-1:0]                mem_wdata;
   logic [BLOCK_BITS-1:0]                mem_rdata;
   logic                                 mem_rvalid;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_rvalid,
      output wr_gnt, rd_gnt, rd_data, rd_valid,
      output mem_we, mem_re, mem_w_addr, mem_r_addr, mem_wdata
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata, mem_rvalid,
      input  wr_gnt, rd_gnt, rd_data, rd_valid,
      input  mem_we, mem_re, mem_w_addr, mem_r_addr, mem_wdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - independent round-robin write/read arbiters in front of a single-port-pair SRAM
module sram_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_W     = mem_pkg::ADDR_W,
   parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);
   localparam int              PW   = $clog2(NUM_PORTS);
   localparam logic [PW:0]     NP   = (PW+1)'(NUM_PORTS);
   localparam logic [PW-1:0]   LAST = PW'(NUM_PORTS-1);

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           wr_pick, rd_pick;
   logic                  wr_hit, rd_hit;
   logic [PW-1:0]         wr_idx, rd_idx;
   logic                  pend_valid;
   logic [PW-1:0]         pend_tag;
   logic [ADDR_W-1:0]     w_addr_c, r_addr_c;
   logic [BLOCK_BITS-1:0] wdata_c;

   // Returns {hit, index}; the search walks upward from ptr and wraps past NUM_PORTS-1.
   function automatic logic [PW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                           input logic [PW-1:0] ptr);
      logic [PW:0] res;
      logic [PW:0] s;
      res = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         s = {1'b0, ptr} + (PW+1)'(i);
         if (s >= NP) s = s - NP;
         if (!res[PW] && req[s[PW-1:0]]) res = {1'b1, s[PW-1:0]};
      end
      return res;
   endfunction

   assign wr_pick = rr_pick(bus.wr_req, wr_ptr);
   assign rd_pick = rr_pick(bus.rd_req, rd_ptr);
   assign wr_hit  = wr_pick[PW] & ~rst;
   assign rd_hit  = rd_pick[PW] & ~rst;
   assign wr_idx  = wr_pick[PW-1:0];
   assign rd_idx  = rd_pick[PW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pend_valid <= 1'b0;
         pend_tag   <= '0;
      end else begin
         if (wr_hit) wr_ptr <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
         if (rd_hit) rd_ptr <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
         pend_valid <= rd_hit;
         if (rd_hit) pend_tag <= rd_idx;
      end
   end

   always_comb begin
      bus.wr_gnt = '0;
      bus.rd_gnt = '0;
      w_addr_c   = '0;
      wdata_c    = '0;
      r_addr_c   = '0;
      if (wr_hit) begin
         bus.wr_gnt = NUM_PORTS'(1) << wr_idx;
         w_addr_c   = bus.wr_addr[wr_idx];
         wdata_c    = bus.wr_data[wr_idx];
      end
      if (rd_hit) begin
         bus.rd_gnt = NUM_PORTS'(1) << rd_idx;
         r_addr_c   = bus.rd_addr[rd_idx];
      end
   end

   assign bus.mem_we     = wr_hit;
   assign bus.mem_re     = rd_hit;
   assign bus.mem_w_addr = w_addr_c;
   assign bus.mem_wdata  = wdata_c;
   assign bus.mem_r_addr = r_addr_c;
   assign bus.rd_data    = bus.mem_rdata;

   // A response with no registered read behind it is not routed anywhere.
   always_comb begin
      bus.rd_valid = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         bus.rd_valid[p] = pend_valid & bus.mem_rvalid & (pend_tag == PW'(p));
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed scoreboard bench for sram_arbiter
module tb_sram_arbiter;
   typedef struct {
      logic [3:0] vld;
      logic [7:0] data;
   } rd_exp_t;

   logic     clk = 1'b0;
   logic     rst;
   int       total = 0;
   int       bad = 0;
   rd_exp_t  exp_q[$];
   logic [7:0] sb_mem [256];
   logic [7:0] mem    [256] = '{default: 8'h00};
   logic [3:0] last_rd_gnt;

   sram_arbiter_if #(.NUM_PORTS(4), .ADDR_W(8), .BLOCK_BITS(8)) bus ();

   sram_arbiter #(.NUM_PORTS(4), .ADDR_W(8), .BLOCK_BITS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // SRAM model: one-cycle read, read-before-write on a same-address collision.
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_w_addr] <= bus.mem_wdata;
      bus.mem_rvalid <= bus.mem_re;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_r_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic step(input string tag, input logic [3:0] ewg, input logic [3:0] erg);
      rd_exp_t e;
      int      wi, ri;
      @(negedge clk);
      wi = oh_idx(ewg);
      ri = oh_idx(erg);
      last_rd_gnt = bus.rd_gnt;
      chk({tag, ".wr_gnt"}, 32'(bus.wr_gnt), 32'(ewg));
      chk({tag, ".rd_gnt"}, 32'(bus.rd_gnt), 32'(erg));
      chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'(|ewg));
      chk({tag, ".mem_re"}, 32'(bus.mem_re), 32'(|erg));
      chk({tag, ".mem_w_addr"}, 32'(bus.mem_w_addr), (ewg != 0) ? 32'(bus.wr_addr[wi]) : 32'd0);
      chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), (ewg != 0) ? 32'(bus.wr_data[wi]) : 32'd0);
      chk({tag, ".mem_r_addr"}, 32'(bus.mem_r_addr), (erg != 0) ? 32'(bus.rd_addr[ri]) : 32'd0);
      if (exp_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(e.vld));
         if (e.vld != 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(e.data));
      end
      e.vld  = erg;
      e.data = (erg != 0) ? sb_mem[bus.rd_addr[ri]] : 8'h00;
      exp_q.push_back(e);
      if (ewg != 0) sb_mem[bus.wr_addr[wi]] = bus.wr_data[wi];
      @(posedge clk);
      #1;
   endtask

   initial begin
      int since_p0;
      for (int i = 0; i < 256; i++) sb_mem[i] = 8'h00;
      rst         = 1'b1;
      bus.wr_req  = 4'hF;
      bus.rd_req  = 4'hF;
      for (int p = 0; p < 4; p++) begin
         bus.wr_addr[p] = 8'h20 + 8'(p);
         bus.wr_data[p] = 8'h40 + 8'(p);
         bus.rd_addr[p] = 8'h20 + 8'(p);
      end
      exp_q.push_back('{4'b0, 8'h00});
      step("reset", 4'b0000, 4'b0000);

      rst        = 1'b0;
      bus.rd_req = 4'b0000;
      for (int k = 0; k < 8; k++) step("rr_wr", 4'(1 << (k % 4)), 4'b0000);

      bus.wr_req = 4'b0100; bus.wr_addr[2] = 8'd5; bus.wr_data[2] = 8'hA5;
      step("wr5", 4'b0100, 4'b0000);
      bus.wr_req = 4'b0000; bus.rd_req = 4'b0001; bus.rd_addr[0] = 8'd5;
      step("rd5", 4'b0000, 4'b0001);
      bus.rd_req = 4'b0000; bus.wr_req = 4'b0010; bus.wr_addr[1] = 8'd7; bus.wr_data[1] = 8'h11;
      step("wr7_old", 4'b0010, 4'b0000);
      bus.wr_data[1] = 8'h3C; bus.rd_req = 4'b1000; bus.rd_addr[3] = 8'd7;
      step("wr_rd7", 4'b0010, 4'b1000);
      bus.wr_req = 4'b0000; bus.rd_req = 4'b0001; bus.rd_addr[0] = 8'd7;
      step("rd7_new", 4'b0000, 4'b0001);

      bus.rd_addr[0] = 8'h20; bus.rd_addr[3] = 8'h23;
      for (int k = 0; k < 7; k++) begin
         bus.rd_req = (k % 2 == 0) ? 4'b1000 : 4'b0001;
         step("alt", 4'b0000, bus.rd_req);
      end

      bus.rd_req = 4'hF;
      for (int p = 0; p < 4; p++) bus.rd_addr[p] = 8'h20 + 8'(p);
      since_p0 = 0;
      for (int k = 0; k < 8; k++) begin
         step("fair", 4'b0000, 4'(1 << (k % 4)));
         since_p0 = last_rd_gnt[0] ? 0 : since_p0 + 1;
         chk("fair.p0_wait_ok", 32'(since_p0 < 4), 32'd1);
      end

      bus.rd_req = 4'b0010;
      step("pre_rst", 4'b0000, 4'b0010);
      rst = 1'b1; bus.rd_req = 4'b0000;
      exp_q.delete();
      exp_q.push_back('{4'b0, 8'h00});
      step("in_rst", 4'b0000, 4'b0000);
      rst = 1'b0;
      bus.rd_req = 4'b1010; bus.wr_req = 4'b1010;
      bus.wr_addr[1] = 8'h30; bus.wr_data[1] = 8'h77;
      bus.wr_addr[3] = 8'h33; bus.wr_data[3] = 8'h88;
      step("post_rst", 4'b0010, 4'b0010);
      bus.rd_req = 4'b0000; bus.wr_req = 4'b0000;
      step("idle1", 4'b0000, 4'b0000);
      step("idle2", 4'b0000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter ADDR_W, default mem_pkg::ADDR_W, block address width.
REQ-003 Parameter BLOCK_BITS, default mem_pkg::BLOCK_BITS, block data width.
REQ-004 Port clk, input, 1, single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1, asynchronous, active-high reset.
REQ-006 Port wr_req, input, NUM_PORTS, per-port write request.
REQ-007 Port wr_addr, input, NUM_PORTS x ADDR_W, per-port write address.
REQ-008 Port wr_data, input, NUM_PORTS x BLOCK_BITS, per-port write data.
REQ-009 Port wr_gnt, output, NUM_PORTS, one-hot write grant.
REQ-010 Port rd_req, input, NUM_PORTS, per-port read request.
REQ-011 Port rd_addr, input, NUM_PORTS x ADDR_W, per-port read address.
REQ-012 Port rd_gnt, output, NUM_PORTS, one-hot read grant.
REQ-013 Port rd_data, output, BLOCK_BITS, read data broadcast to all ports.
REQ-014 Port rd_valid, output, NUM_PORTS, one-hot read-data-valid for the owning port.
REQ-015 Ports mem_we, mem_re (1), mem_w_addr, mem_r_addr (ADDR_W), mem_wdata (BLOCK_BITS), outputs; SRAM command bus.
REQ-016 Ports mem_rdata (BLOCK_BITS), mem_rvalid (1), inputs; SRAM response, 1 cycle after mem_re.

Function
REQ-017 Write and read arbitration are independent; both may grant in the same cycle.
REQ-018 Grants are combinational from the current requests and the round-robin pointer: at most one bit set per grant vector, zero when no request.
REQ-019 Round-robin: the search starts at the port index held in the pointer and ascends with wrap from NUM_PORTS-1 to 0; the first requesting port wins.
REQ-020 On a grant to port k, the pointer becomes (k+1) mod NUM_PORTS at the next edge; with no grant, the pointer holds.
REQ-021 Handshake: a transfer occurs in any cycle with req&gnt set for a port; requesters hold req/addr/data stable until granted; a request may be dropped before grant.
REQ-022 Fairness: a continuously asserted request is granted within NUM_PORTS cycles.
REQ-023 mem_we = |wr_gnt; mem_w_addr/mem_wdata = the granted port's wr_addr/wr_data; both zero when there is no grant.
REQ-024 mem_re = |rd_gnt; mem_r_addr = the granted port's rd_addr, zero when there is no grant.
REQ-025 On a read grant, a pending-valid flag and a port tag (clog2(NUM_PORTS) bits) are registered.
REQ-026 rd_valid[p] = pend_valid & mem_rvalid & (pend_tag==p); rd_data = mem_rdata unmodified.
REQ-027 Read latency: rd_valid is asserted exactly 1 cycle after the rd_gnt cycle; back-to-back reads are supported every cycle.
REQ-028 Read and write to the same address in the same cycle: no forwarding; the read returns the prior contents.
REQ-029 A mem_rvalid without pend_valid (for example, after reset) is ignored: rd_valid is all zeros.

Reset
REQ-030 While rst is high: both pointers = 0; pend_valid = 0; pend_tag = 0; rd_valid = 0.
REQ-031 Grants and mem_* command outputs stay purely combinational during reset and are forced to 0 while rst is high.
REQ-032 Reset during a pending read drops that read: no rd_valid is produced for it after reset releases.
REQ-033 The first arbitration after reset starts at port 0.

Verification
REQ-034 Out of reset with all four wr_req high for 8 cycles -> wr_gnt sequence 0001, 0010, 0100, 1000, then repeating; mem_we = 1 every cycle.
REQ-035 Port 2 writes 0xA5 to address 5, then port 0 reads address 5 -> the cycle after rd_gnt=0001, rd_valid=0001 and rd_data=0xA5.
REQ-036 Same cycle: port 1 writes 0x3C to address 7 (old value 0x11) and port 3 reads address 7 -> rd_valid=1000 with rd_data=0x11; a later read returns 0x3C.
REQ-037 Ports 0 and 3 read on alternate cycles, back-to-back -> each rd_valid lands on the correct port one cycle after its grant, with no gaps.
REQ-038 Assert rst on the cycle after a read grant -> rd_valid stays 0; after release, the pointer is 0 and a port-1 request with port 3 requesting gives rd_gnt=0010.
REQ-039 Port 0 continuously requesting while ports 1-3 request -> port 0 is granted within 4 cycles every time.
